// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core front end.
//   WORD_W           - datapath / address width
//   PC_STEP          - byte distance between consecutive instruction words
//   PC_READ_OFFSET   - architectural PC read value is the instruction address plus this
//   DEFAULT_RESET_PC - default first fetch address
//   fetch_entry_t    - prefetch queue entry {pc, instr}
package arm_pkg;

  localparam int unsigned WORD_W           = 32;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] PC_READ_OFFSET   = 32'd8;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch queue of fetch_entry_t.
//   clk, reset  - rising-edge clock, asynchronous active-high reset
//   push, wdata - write an entry (ignored when full with no simultaneous pop)
//   pop         - drop the head entry (ignored when empty)
//   flush       - discard all entries; wins over push/pop in the same cycle
//   head        - current head entry (all zero after reset)
//   count       - occupancy, 0..DEPTH
module fetch_fifo
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             wdata,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word fetches, buffers returned words in
// an in-order prefetch queue and presents them with a valid/ready handshake.
// A redirect flushes the queue and all in-flight fetches and restarts at the
// (word-aligned) target.
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to fault and halt on a
// redirect whose target is not word aligned (cleared only by reset).
//
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   imem_req/addr/gnt             - fetch request channel (accepted on req&gnt)
//   imem_rvalid/rdata             - in-order read responses
//   instr_valid/instr/instr_pc    - queue head
//   pc_plus8                      - instr_pc + 8
//   instr_ready                   - consumer pops the head on valid&ready
//   redirect, redirect_target     - taken branch and its destination
//   fetch_fault                   - sticky misaligned-target fault
module fetch_unit
  import arm_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pc_plus8,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        fetch_fault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  // Back-to-back redirects against slow memory can leave more than DEPTH
  // fetches outstanding (live plus to-be-dropped), so these get headroom.
  localparam int unsigned IW = CW + 2;

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;     // address the next kept response belongs to
  logic [CW-1:0] count;
  logic [IW-1:0] inflight;
  logic [IW-1:0] drop;
  logic [IW-1:0] inflight_nxt;
  logic [31:0]   target_al;
  logic          halted;
  logic          grant;
  logic          resp_drop;
  logic          push;
  logic          pop;
  logic          credit_ok;
  fetch_entry_t  head;
  fetch_entry_t  wdata;

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                            halted <= 1'b0;
    else if (redirect && (redirect_target[1:0] != 2'b00)) halted <= 1'b1;
  end
  assign fetch_fault = halted;
`else
  logic unused_target_bits;
  assign unused_target_bits = ^redirect_target[1:0];
  assign halted             = 1'b0;
  assign fetch_fault        = 1'b0;
`endif

  assign target_al    = {redirect_target[31:2], 2'b00};
  // Credits: queued plus live in-flight fetches (dropped ones free their slot).
  assign credit_ok    = ((IW'(count) + inflight - drop) < IW'(DEPTH)) && (inflight != '1);
  assign imem_req     = !reset && !halted && credit_ok;
  assign imem_addr    = fetch_pc;
  assign grant        = imem_req && imem_gnt;
  assign resp_drop    = imem_rvalid && (drop != '0);
  // A response landing in the redirect cycle belongs to the old stream.
  assign push         = imem_rvalid && (drop == '0) && !redirect;
  assign pop          = instr_valid && instr_ready;
  assign inflight_nxt = inflight + IW'(grant) - IW'(imem_rvalid);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect) begin
        fetch_pc <= target_al;
        rsp_pc   <= target_al;
        // Everything still outstanding after this cycle, including a fetch
        // granted right now, belongs to the abandoned stream.
        drop     <= inflight_nxt;
      end else begin
        if (grant)     fetch_pc <= fetch_pc + PC_STEP;
        if (push)      rsp_pc   <= rsp_pc + PC_STEP;
        if (resp_drop) drop     <= drop - 1'b1;
      end
    end
  end

  assign wdata = '{pc: rsp_pc, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .flush (redirect),
    .head  (head),
    .count (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign pc_plus8    = head.pc + PC_READ_OFFSET;

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus8;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        fetch_fault;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_gnt        (imem_gnt),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .pc_plus8        (pc_plus8),
    .instr_ready     (instr_ready),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  // ---------------- reference model state ----------------
  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } fetch_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  fetch_t      pending[$];    // memory-side outstanding fetches, in order
  exp_t        expq[$];       // scoreboard: expected instruction stream
  logic [31:0] grant_log[$];
  logic [31:0] exp_next;
  int unsigned epoch = 0;
  int unsigned occ = 0;       // modelled queue occupancy
  int unsigned cyc = 0;
  int unsigned last_due = 0;
  int unsigned pops = 0;
  bit          halted_m = 0;
  bit          redir_prev = 0;
  logic [31:0] redir_tgt;

  int unsigned gnt_pct = 100;
  int unsigned rdy_pct = 100;
  int unsigned lat_lo = 1;
  int unsigned lat_hi = 1;

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
  endtask

  function automatic void restart(input logic [31:0] start);
    expq.delete();
    exp_next = start & ~32'h3;
  endfunction

  // ---------------- memory / consumer driver ----------------
  initial begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    instr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      imem_gnt    = ($urandom_range(99) < gnt_pct);
      instr_ready = ($urandom_range(99) < rdy_pct);
      if (!reset && pending.size() > 0 && pending[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pending[0].addr);
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    fetch_t      f;
    exp_t        e;
    int unsigned lat, due, live;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        pending.delete();
        occ        = 0;
        halted_m   = 0;
        redir_prev = 0;
        last_due   = 0;
        epoch++;
        restart(RESET_PC);
        continue;
      end
      while (!halted_m && expq.size() < 8) begin
        expq.push_back('{exp_next, mem_word(exp_next)});
        exp_next = exp_next + 32'd4;
      end

      live = 0;
      foreach (pending[i]) if (pending[i].epoch == epoch) live++;
      check("valid_vs_model", {31'b0, instr_valid}, {31'b0, occ != 0});
      check("credit_bound", {31'b0, (occ + live) <= DEPTH}, 32'd1);
      if (halted_m) check("halted_req", {31'b0, imem_req}, 32'd0);
      if (redir_prev && !halted_m) begin
        check("redir_addr", imem_addr, redir_tgt & ~32'h3);
        check("redir_req", {31'b0, imem_req}, 32'd1);
      end
      redir_prev = 0;

      if (imem_rvalid && pending.size() > 0) begin
        f = pending.pop_front();
        if (f.epoch == epoch) occ++;
      end
      if (imem_req && imem_gnt) begin
        lat = $urandom_range(lat_hi, lat_lo);
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pending.push_back('{imem_addr, epoch, due});
        grant_log.push_back(imem_addr);
      end
      if (instr_valid && instr_ready) begin
        pops++;
        if (expq.size() == 0) begin
          timeout("unexpected_pop");
        end else begin
          e = expq.pop_front();
          check("instr_pc", instr_pc, e.pc);
          check("instr", instr, e.word);
          check("pc_plus8", pc_plus8, e.pc + 32'd8);
        end
        if (occ > 0) occ--;
      end
      if (redirect) begin
        epoch++;
        occ        = 0;
        redir_prev = 1;
        redir_tgt  = redirect_target;
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect_target[1:0] != 2'b00) begin
          halted_m = 1;
          expq.delete();
        end else begin
          restart(redirect_target);
        end
`else
        restart(redirect_target);
`endif
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed + random stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int unsigned g, input int unsigned r, input int unsigned lo, input int unsigned hi);
    @(negedge clk);
    reset    = 1'b1;
    redirect = 1'b0;
    gnt_pct  = g;
    rdy_pct  = r;
    lat_lo   = lo;
    lat_hi   = hi;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic pulse_redirect(input logic [31:0] tgt);
    redirect        = 1'b1;
    redirect_target = tgt;
    tick();
    redirect = 1'b0;
  endtask

  initial begin
    bit          ok;
    int unsigned gl0;
    int unsigned p0;
    reset           = 1'b1;
    redirect        = 1'b0;
    redirect_target = '0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_pc_plus8", pc_plus8, 32'd8);
    check("rst_fault", {31'b0, fetch_fault}, 32'd0);

    // Streaming: grant every cycle, 1-cycle response, always ready
    do_reset(100, 100, 1, 1);
    for (int unsigned k = 0; k < 10; k++) begin
      if (k > 0) tick();
      check("stream_req", {31'b0, imem_req}, 32'd1);
      check("stream_addr", imem_addr, 4 * k);
      check("stream_valid", {31'b0, instr_valid}, {31'b0, k >= 2});
      if (k >= 2) begin
        check("stream_pc", instr_pc, 4 * (k - 2));
        check("stream_pc8", pc_plus8, 4 * (k - 2) + 8);
      end
    end

    // Back-pressure: exactly DEPTH grants, head held, then resume at 16
    do_reset(100, 0, 1, 1);
    gl0 = grant_log.size();
    repeat (12) tick();
    check("stall_grants", grant_log.size() - gl0, DEPTH);
    check("stall_req", {31'b0, imem_req}, 32'd0);
    check("stall_head_pc", instr_pc, 32'd0);
    check("stall_valid", {31'b0, instr_valid}, 32'd1);
    rdy_pct = 100;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (grant_log.size() >= gl0 + 5) begin ok = 1; break; end
    end
    if (ok) check("resume_addr", grant_log[gl0 + 4], 32'd16);
    else    timeout("resume_addr");

    // Redirect with fetches in flight and entries queued
    do_reset(100, 0, 3, 3);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (occ == 2 && pending.size() == 2) begin ok = 1; break; end
    end
    if (!ok) timeout("inflight_setup");
    pulse_redirect(32'h0000_0100);
    check("redir_valid0", {31'b0, instr_valid}, 32'd0);
    rdy_pct = 100;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      if (instr_valid) begin ok = 1; break; end
      tick();
    end
    if (ok) check("redir_first_pc", instr_pc, 32'h0000_0100);
    else    timeout("redir_first_pc");

    // Redirect coinciding with grant of 8 and response of 4
    do_reset(100, 100, 1, 1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_addr == 32'd8) begin ok = 1; break; end
      tick();
    end
    if (!ok) timeout("coincide_setup");
    check("coincide_rvalid", {31'b0, imem_rvalid}, 32'd1);
    check("coincide_grant", {31'b0, imem_req && imem_gnt}, 32'd1);
    pulse_redirect(32'h0000_0200);
    check("coincide_valid0", {31'b0, instr_valid}, 32'd0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin ok = 1; break; end
      tick();
    end
    if (ok) check("coincide_first_pc", instr_pc, 32'h0000_0200);
    else    timeout("coincide_first_pc");

    // Misaligned redirect target
    do_reset(100, 100, 1, 2);
    repeat (6) tick();
    pulse_redirect(32'h0000_0102);
`ifdef FETCH_ALIGN_CHECK_EN
    check("fault_set", {31'b0, fetch_fault}, 32'd1);
    check("fault_req", {31'b0, imem_req}, 32'd0);
    repeat (20) tick();
    check("fault_sticky", {31'b0, fetch_fault}, 32'd1);
    check("fault_req_held", {31'b0, imem_req}, 32'd0);
    check("fault_valid", {31'b0, instr_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("fault_cleared", {31'b0, fetch_fault}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("fault_restart_req", {31'b0, imem_req}, 32'd1);
    check("fault_restart_addr", imem_addr, RESET_PC);
`else
    check("nofault", {31'b0, fetch_fault}, 32'd0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin ok = 1; break; end
      tick();
    end
    if (ok) check("misalign_first_pc", instr_pc, 32'h0000_0100);
    else    timeout("misalign_first_pc");
`endif

    // Randomized: variable latency, random grant/ready, random redirects
    do_reset(60, 70, 1, 5);
    repeat (5) tick();
    pulse_redirect(32'hFFFF_FFF8);   // exercises PC wrap
    p0 = pops;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(49) == 0) begin
`ifdef FETCH_ALIGN_CHECK_EN
        redirect_target = $urandom & 32'h0000_0FFC;
`else
        redirect_target = $urandom & 32'h0000_0FFF;
`endif
        redirect = 1'b1;
      end else begin
        redirect = 1'b0;
      end
      tick();
    end
    redirect = 1'b0;
    repeat (10) tick();
    check("random_progress", {31'b0, (pops - p0) > 300}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
